// File: rtl/hdmi_timing_pkg.sv
// Shared types and default 640x480@60 timing for the HDMI video timing controller.
package hdmi_timing_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_t;

    typedef enum logic [1:0] {
        PH_SYNC,
        PH_BACK,
        PH_ACTIVE,
        PH_FRONT
    } phase_t;

    localparam int CNT_W_DEF = 12;

    localparam int H_SYNC_640   = 96;
    localparam int H_BACK_640   = 48;
    localparam int H_ACTIVE_640 = 640;
    localparam int H_FRONT_640  = 16;
    localparam int V_SYNC_480   = 2;
    localparam int V_BACK_480   = 33;
    localparam int V_ACTIVE_480 = 480;
    localparam int V_FRONT_480  = 10;

endpackage

// File: rtl/hdmi_timing_ctrl_axis_cnt.sv
// Generic wrapping counter for one video axis, decoding SYNC/BACK/ACTIVE/FRONT phases.
module timing_axis_cnt
    import hdmi_timing_pkg::*;
#(
    parameter int SYNC   = H_SYNC_640,
    parameter int BACK   = H_BACK_640,
    parameter int ACTIVE = H_ACTIVE_640,
    parameter int FRONT  = H_FRONT_640,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             clear,
    input  logic             step,
    output logic [CNT_W-1:0] cnt,
    output phase_t           phase,
    output logic             last
);

    localparam logic [CNT_W-1:0] SYNC_END   = CNT_W'(SYNC);
    localparam logic [CNT_W-1:0] BACK_END   = CNT_W'(SYNC + BACK);
    localparam logic [CNT_W-1:0] ACTIVE_END = CNT_W'(SYNC + BACK + ACTIVE);
    localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(SYNC + BACK + ACTIVE + FRONT - 1);

    // last is combinational so the vertical axis can step in the same cycle the line ends
    assign last = (cnt == LAST_CNT);

    always_ff @(posedge sys_clk) begin
        if (sys_rst || clear) begin
            cnt <= '0;
        end else if (step) begin
            cnt <= last ? '0 : cnt + 1'b1;
        end
    end

    always_comb begin
        if (cnt < SYNC_END) begin
            phase = PH_SYNC;
        end else if (cnt < BACK_END) begin
            phase = PH_BACK;
        end else if (cnt < ACTIVE_END) begin
            phase = PH_ACTIVE;
        end else begin
            phase = PH_FRONT;
        end
    end

endmodule

// File: rtl/hdmi_timing_ctrl.sv
// Video timing controller: frame FSM, h/v counters and a two-stage pixel request / sync pipeline.
module hdmi_timing_ctrl
    import hdmi_timing_pkg::*;
#(
    parameter int H_SYNC   = H_SYNC_640,
    parameter int H_BACK   = H_BACK_640,
    parameter int H_ACTIVE = H_ACTIVE_640,
    parameter int H_FRONT  = H_FRONT_640,
    parameter int V_SYNC   = V_SYNC_480,
    parameter int V_BACK   = V_BACK_480,
    parameter int V_ACTIVE = V_ACTIVE_480,
    parameter int V_FRONT  = V_FRONT_480,
    parameter bit SYNC_POL = 1'b0,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             en,
    output logic             busy,
    output logic             pix_req,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic             frame_start
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam logic [CNT_W-1:0] H_OFS = CNT_W'(H_SYNC + H_BACK);
    localparam logic [CNT_W-1:0] V_OFS = CNT_W'(V_SYNC + V_BACK);

    if (H_TOTAL >= (1 << CNT_W) || V_TOTAL >= (1 << CNT_W)) begin : g_bad_params
        $error("hdmi_timing_ctrl: H_TOTAL or V_TOTAL does not fit in CNT_W bits");
    end

    state_t           state;
    logic             clear;
    logic             running;
    logic             frame_last;
    logic             req_next;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    phase_t           h_phase;
    phase_t           v_phase;
    logic             h_last;
    logic             v_last;
    logic             s1_hsync;
    logic             s1_vsync;
    logic             s1_fstart;

    assign clear      = (state == ST_IDLE);
    assign running    = (state != ST_IDLE);
    assign frame_last = h_last && v_last;
    assign req_next   = running && (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);

    timing_axis_cnt #(
        .SYNC(H_SYNC), .BACK(H_BACK), .ACTIVE(H_ACTIVE), .FRONT(H_FRONT), .CNT_W(CNT_W)
    ) u_h_cnt (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .clear(clear), .step(1'b1),
        .cnt(h_cnt), .phase(h_phase), .last(h_last)
    );

    timing_axis_cnt #(
        .SYNC(V_SYNC), .BACK(V_BACK), .ACTIVE(V_ACTIVE), .FRONT(V_FRONT), .CNT_W(CNT_W)
    ) u_v_cnt (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .clear(clear), .step(h_last),
        .cnt(v_cnt), .phase(v_phase), .last(v_last)
    );

    // A frame always runs to its last pixel; at that point en alone decides whether to continue
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (en) begin
                        state <= ST_RUN;
                        busy  <= 1'b1;
                    end
                end
                ST_RUN, ST_DRAIN: begin
                    if (frame_last) begin
                        state <= en ? ST_RUN : ST_IDLE;
                        busy  <= en;
                    end else begin
                        state <= en ? ST_RUN : ST_DRAIN;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Stage 1 issues the pixel request; stage 2 delays syncs to line up with de
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            pix_req     <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            s1_hsync    <= 1'b0;
            s1_vsync    <= 1'b0;
            s1_fstart   <= 1'b0;
            de          <= 1'b0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            frame_start <= 1'b0;
        end else begin
            pix_req <= req_next;
            if (req_next) begin
                pix_x <= h_cnt - H_OFS;
                pix_y <= v_cnt - V_OFS;
            end
            s1_hsync    <= running && (h_phase == PH_SYNC);
            s1_vsync    <= running && (v_phase == PH_SYNC);
            s1_fstart   <= running && (h_cnt == '0) && (v_cnt == '0);
            de          <= pix_req;
            hsync       <= s1_hsync ? SYNC_POL : ~SYNC_POL;
            vsync       <= s1_vsync ? SYNC_POL : ~SYNC_POL;
            frame_start <= s1_fstart;
        end
    end

endmodule

// File: tb/tb_hdmi_timing_ctrl.sv
// Self-checking bench for hdmi_timing_ctrl on a small 10x6 timing, with a frame-position reference model.
module tb_hdmi_timing_ctrl;

    localparam int HS = 2, HB = 2, HA = 4, HF = 2;
    localparam int VS = 1, VB = 1, VA = 3, VF = 1;
    localparam int HT = HS + HB + HA + HF;
    localparam int VT = VS + VB + VA + VF;
    localparam int FT = HT * VT;
    localparam int CW = 12;

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b1;
    logic          en = 1'b0;
    logic          busy;
    logic          pix_req;
    logic [CW-1:0] pix_x;
    logic [CW-1:0] pix_y;
    logic          hsync;
    logic          vsync;
    logic          de;
    logic          frame_start;

    hdmi_timing_ctrl #(
        .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
        .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF),
        .SYNC_POL(1'b0), .CNT_W(CW)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .en(en), .busy(busy),
        .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y),
        .hsync(hsync), .vsync(vsync), .de(de), .frame_start(frame_start)
    );

    always #5 sys_clk = ~sys_clk;

    int errors = 0;
    int checks = 0;
    int off = 0;
    int de_cnt = 0;
    int hs_lo = 0;
    int vs_lo = 0;

    // reference model: frame position plus what was presented one and two cycles ago
    bit m_busy = 1'b0;
    int m_pos = 0;
    bit s1_v = 1'b0;
    int s1_p = 0;
    bit s2_v = 1'b0;
    int s2_p = 0;
    int m_x = 0;
    int m_y = 0;

    function automatic bit is_active(input int p);
        int h, v;
        h = p % HT;
        v = p / HT;
        return (h >= HS + HB) && (h < HS + HB + HA) && (v >= VS + VB) && (v < VS + VB + VA);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s at offset %0d: got %0h, want %0h", tag, off, obs, expv);
        end
    endtask

    task automatic model_edge(input bit e, input bit r);
        if (r) begin
            m_busy = 1'b0; m_pos = 0;
            s1_v = 1'b0; s2_v = 1'b0;
            m_x = 0; m_y = 0;
        end else begin
            s2_v = s1_v; s2_p = s1_p;
            s1_v = m_busy; s1_p = m_pos;
            if (m_busy && is_active(m_pos)) begin
                m_x = (m_pos % HT) - (HS + HB);
                m_y = (m_pos / HT) - (VS + VB);
            end
            if (!m_busy) begin
                if (e) begin
                    m_busy = 1'b1;
                    m_pos = 0;
                end
            end else if (m_pos == FT - 1) begin
                m_busy = e;
                m_pos = 0;
            end else begin
                m_pos++;
            end
        end
    endtask

    task automatic check_output();
        check("busy", 32'(busy), 32'(m_busy));
        check("pix_req", 32'(pix_req), 32'(s1_v && is_active(s1_p)));
        check("pix_x", 32'(pix_x), 32'(m_x));
        check("pix_y", 32'(pix_y), 32'(m_y));
        check("de", 32'(de), 32'(s2_v && is_active(s2_p)));
        check("hsync", 32'(hsync), 32'(!(s2_v && (s2_p % HT) < HS)));
        check("vsync", 32'(vsync), 32'(!(s2_v && (s2_p / HT) < VS)));
        check("frame_start", 32'(frame_start), 32'(s2_v && s2_p == 0));
    endtask

    task automatic apply_stimulus(input bit e, input bit r);
        en = e;
        sys_rst = r;
        @(posedge sys_clk);
        model_edge(e, r);
        off++;
        @(negedge sys_clk);
        if (de === 1'b1) de_cnt++;
        if (hsync === 1'b0) hs_lo++;
        if (vsync === 1'b0) vs_lo++;
        check_output();
    endtask

    task automatic go_idle();
        for (int i = 0; i < 200 && busy !== 1'b0; i++) apply_stimulus(1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0);
        check("idle_bound", 32'(busy), 32'd0);
    endtask

    task automatic start_run();
        off = -1;
        de_cnt = 0;
        hs_lo = 0;
        vs_lo = 0;
        apply_stimulus(1'b1, 1'b0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit r_en;
        bit r_rst;

        for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b1);

        // idle after reset release: everything inactive
        for (int i = 0; i < 20; i++) begin
            apply_stimulus(1'b0, 1'b0);
            check("idle_hsync", 32'(hsync), 32'd1);
            check("idle_de", 32'(de), 32'd0);
        end

        // continuous run: frame_start spacing, de/sync counts, coordinates
        start_run();
        check("start_busy", 32'(busy), 32'd1);
        for (int k = 1; k <= 63; k++) begin
            apply_stimulus(1'b1, 1'b0);
            if (off == 2 || off == 62) check("fs_period", 32'(frame_start), 32'd1);
            if (off == 24) check("req_early", 32'(pix_req), 32'd0);
            if (off == 25) begin
                check("req_first", 32'(pix_req), 32'd1);
                check("req_first_xy", {pix_y[15:0], pix_x[15:0]}, 32'h0000_0000);
            end
            if (off == 26) check("de_first", 32'(de), 32'd1);
            if (off == 35) check("req_row1_xy", {pix_y[15:0], pix_x[15:0]}, 32'h0001_0000);
            if (off == 48) check("req_last_xy", {pix_y[15:0], pix_x[15:0]}, 32'h0002_0003);
            if (off == 49) check("req_after_last", 32'(pix_req), 32'd0);
            if (off == 61) begin
                check("de_per_frame", 32'(de_cnt), 32'd12);
                check("hsync_low_per_frame", 32'(hs_lo), 32'd12);
                check("vsync_low_per_frame", 32'(vs_lo), 32'd10);
            end
        end
        go_idle();

        // en dropped mid-frame: frame completes then controller idles
        start_run();
        for (int k = 1; k <= 64; k++) begin
            apply_stimulus(off < 30, 1'b0);
            if (off == 59) check("drain_busy", 32'(busy), 32'd1);
            if (off == 60) check("drain_busy_fall", 32'(busy), 32'd0);
            if (off == 62) begin
                check("drain_no_fs", 32'(frame_start), 32'd0);
                check("drain_de_count", 32'(de_cnt), 32'd12);
                check("drain_hsync_off", 32'(hsync), 32'd1);
                check("drain_de_off", 32'(de), 32'd0);
            end
        end
        go_idle();

        // en re-raised during drain: frames continue without a gap
        start_run();
        for (int k = 1; k <= 66; k++) begin
            apply_stimulus(off < 30 || off >= 40, 1'b0);
            if (off >= 55) check("redrive_busy", 32'(busy), 32'd1);
            if (off == 62) check("redrive_fs", 32'(frame_start), 32'd1);
        end
        go_idle();

        // reset mid-frame aborts immediately, then restarts with en still high
        start_run();
        for (int k = 1; k <= 34; k++) begin
            apply_stimulus(1'b1, off == 27);
            if (off == 27) check("pre_reset_de", 32'(de), 32'd1);
            if (off == 28) begin
                check("rst_de", 32'(de), 32'd0);
                check("rst_sync", {31'd0, hsync & vsync}, 32'd1);
                check("rst_busy", 32'(busy), 32'd0);
            end
            if (off == 30) check("restart_fs_early", 32'(frame_start), 32'd0);
            if (off == 31) check("restart_fs", 32'(frame_start), 32'd1);
        end

        // randomized en/reset traffic against the model
        r_en = 1'b1;
        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(0, 39) == 0) r_en = ~r_en;
            r_rst = ($urandom_range(0, 299) == 0);
            apply_stimulus(r_en, r_rst);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hdmi_timing_ctrl.md
Name: hdmi_timing_ctrl

Overview:
Video timing controller that sequences the HDMI colour-bar pixel datapath. It generates horizontal/vertical counters and phases, and drives the encoder-side hsync/vsync/de. It issues a pixel request with X/Y coordinates one cycle ahead of de, so the pattern generator can register its RGB output. It sits between the top-level clocking and the pattern generator / TMDS encoders, all in the pixel clock domain.

Parameters:
H_SYNC, 96, hsync width in pixel clocks
H_BACK, 48, horizontal back porch
H_ACTIVE, 640, active pixels per line
H_FRONT, 16, horizontal front porch
V_SYNC, 2, vsync width in lines
V_BACK, 33, vertical back porch in lines
V_ACTIVE, 480, active lines per frame
V_FRONT, 10, vertical front porch in lines
SYNC_POL, 0, sync active level (0 = active-low)
CNT_W, 12, counter and coordinate width

Ports:
sys_clk  in  1  pixel clock; all logic on its rising edge
sys_rst  in  1  synchronous reset, active-high
en  in  1  run request; level-sensitive
busy  out  1  high while a frame is in progress
pix_req  out  1  the pattern generator must present the pixel (pix_x, pix_y) on the next cycle
pix_x  out  CNT_W  column of the requested pixel, 0..H_ACTIVE-1
pix_y  out  CNT_W  row of the requested pixel, 0..V_ACTIVE-1
hsync  out  1  horizontal sync, polarity per SYNC_POL
vsync  out  1  vertical sync, polarity per SYNC_POL
de  out  1  data enable, high during active video
frame_start  out  1  one-cycle pulse aligned with the first hsync cycle of each frame

Behaviour:
- H_TOTAL = H_SYNC+H_BACK+H_ACTIVE+H_FRONT; V_TOTAL defined likewise.
- Counter h wraps at H_TOTAL-1. Counter v increments only when h = H_TOTAL-1 and wraps at V_TOTAL-1.
- Phase order on each axis: SYNC, BACK, ACTIVE, FRONT. Count 0 is the first SYNC cycle.
- Control FSM has three states:
  - IDLE: counters held at 0, all outputs inactive. If en = 1, go to RUN; h = 0, v = 0 on the next cycle.
  - RUN: counters advance every cycle.
  - If en = 0 is sampled while running, go to DRAIN.
  - DRAIN: counters continue until the cycle with h = H_TOTAL-1 and v = V_TOTAL-1, then return to IDLE. Frames are never truncated.
  - If en returns to 1 during DRAIN, go back to RUN with no gap.
  - At the frame boundary in RUN, wrap to 0 and continue.
- busy = 1 in RUN or DRAIN, 0 in IDLE. It is registered and asserts on the same cycle the counters leave IDLE.
- Pipeline stage 1 (registered from the counters): pix_req = h_active AND v_active. When pix_req = 1, pix_x = h - (H_SYNC+H_BACK) and pix_y = v - (V_SYNC+V_BACK); otherwise pix_x and pix_y hold their last value.
- Pipeline stage 2 (one further register): de = previous pix_req. hsync, vsync and frame_start are also delayed two cycles from the counters, so sync and de stay mutually aligned.
- hsync is active while h is in SYNC; vsync is active while v is in SYNC. Both use the SYNC_POL level.
- frame_start = 1 for the stage-2 cycle corresponding to h = 0, v = 0.
- After return to IDLE, the pipeline flushes. Outputs reach their inactive values 2 cycles after busy falls.
- Reset values: busy 0, pix_req 0, pix_x 0, pix_y 0, de 0, frame_start 0, hsync = vsync = ~SYNC_POL. FSM in IDLE, counters 0, all pipeline registers inactive.
- Reset has priority over en in the same cycle. Reset mid-frame aborts immediately; de falls on the next cycle.
- Arithmetic is unsigned CNT_W bits. Parameters must satisfy H_TOTAL, V_TOTAL < 2^CNT_W; this is checked by an elaboration-time assertion.

Decomposition:
- Package hdmi_timing_pkg holds:
  - the FSM state enum (IDLE, RUN, DRAIN)
  - the phase enum (SYNC, BACK, ACTIVE, FRONT)
  - the CNT_W default
  - the 640x480@60 timing constants
- Sub-module timing_axis_cnt is a generic wrapping counter with phase decode.
  - Ports: sys_clk, sys_rst, clear, step; outputs cnt, phase, last.
  - Instantiated twice: horizontal step = 1; vertical step = h.last.

Test Plan:
Bench parameters: H 2/2/4/2 (H_TOTAL 10), V 1/1/3/1 (V_TOTAL 6), SYNC_POL 0. Counters reach h = 0, v = 0 at cycle N after en rises.
1. Reset release with en = 0 for 20 cycles -> hsync = vsync = 1, de = 0, busy = 0, pix_req = 0 throughout.
2. en held high -> frame_start pulses at N+2 and N+62.
   - Each frame: exactly 12 de cycles, 3 groups of 4.
   - hsync low 2 cycles every 10; vsync low 10 cycles.
3. Coordinates -> pix_req first at N+25 with (0,0), and de first at N+26.
   - pix_req sequence (0,0),(1,0),(2,0),(3,0), then (0,1) at N+35, and (3,2) last.
4. en dropped at N+30 -> frame completes: the 12th de occurs.
   - busy falls at N+60; no frame_start at N+62; outputs are inactive by N+62.
   - Re-raising en at N+40 instead -> continuous frames, no gap.
5. sys_rst pulsed at N+27 (during de) -> at N+28 de = 0, hsync = vsync = 1, busy = 0.
   - en still high -> restart; the next frame_start arrives 3 cycles after reset falls.
